// File: rtl/part_buf_serializer_if.sv
// Handshake bundle between a word source, the part serializer and a part sink.
// The slave modport is the serializer's view; master is the surrounding environment.
interface part_buf_serializer_if #(
    parameter int DATA_W    = 32,
    parameter int NUM_PARTS = 4
);
    localparam int NP_SAFE = (NUM_PARTS < 1) ? 1 : NUM_PARTS;
    localparam int PART_W  = DATA_W / NP_SAFE;
    localparam int IDX_W   = (NP_SAFE > 1) ? $clog2(NP_SAFE) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [PART_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic [15:0]       word_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, word_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, word_count
    );
endinterface

// File: rtl/part_buf_serializer.sv
// Splits each accepted DATA_W word into NUM_PARTS parts of PART_W bits and emits them
// one per output handshake, reloading back-to-back on the final part.
module part_buf_serializer #(
    parameter int DATA_W    = 32,
    parameter int NUM_PARTS = 4,
    parameter int MSB_FIRST = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    part_buf_serializer_if.slave bus
);
    localparam int NP_SAFE = (NUM_PARTS < 1) ? 1 : NUM_PARTS;
    localparam int PART_W  = DATA_W / NP_SAFE;
    localparam int IDX_W   = (NP_SAFE > 1) ? $clog2(NP_SAFE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NP_SAFE - 1);

    generate
        if (NUM_PARTS < 1) begin : g_bad_parts
            $error("part_buf_serializer: NUM_PARTS must be at least 1");
        end else if (DATA_W % NUM_PARTS != 0) begin : g_bad_width
            $error("part_buf_serializer: DATA_W must be a multiple of NUM_PARTS");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  idx_next;
    logic              last_reg;
    logic              valid_reg;
    logic [15:0]       count_reg;
    logic              out_fire;
    logic              in_fire;

    // The outgoing part always sits at the edge the word shifts toward.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign bus.out_data = shift_reg[DATA_W-1 -: PART_W];
            assign shift_next   = shift_reg << PART_W;
        end else begin : g_lsb_first
            assign bus.out_data = shift_reg[PART_W-1:0];
            assign shift_next   = shift_reg >> PART_W;
        end
    endgenerate

    assign out_fire     = valid_reg && bus.out_ready;
    assign bus.in_ready = (state_reg == IDLE) || (out_fire && last_reg);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign idx_next     = idx_reg + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            idx_reg   <= '0;
            last_reg  <= 1'b0;
            valid_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_fire) begin
                        state_reg <= SEND;
                        shift_reg <= bus.in_data;
                        idx_reg   <= '0;
                        last_reg  <= (NP_SAFE == 1);
                        valid_reg <= 1'b1;
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        if (last_reg) begin
                            count_reg <= count_reg + 16'd1;
                            // A word offered alongside the final part loads with no bubble.
                            if (in_fire) begin
                                shift_reg <= bus.in_data;
                                idx_reg   <= '0;
                                last_reg  <= (NP_SAFE == 1);
                            end else begin
                                state_reg <= IDLE;
                                idx_reg   <= '0;
                                last_reg  <= 1'b0;
                                valid_reg <= 1'b0;
                            end
                        end else begin
                            shift_reg <= shift_next;
                            idx_reg   <= idx_next;
                            last_reg  <= (idx_next == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid  = valid_reg;
    assign bus.out_idx    = idx_reg;
    assign bus.out_last   = last_reg;
    assign bus.word_count = count_reg;
endmodule
